// File: rtl/cache_pkg.sv
// Cache-side arbitration types and sizing helpers.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DGRANT,
    IGRANT
  } arb_state_t;

  // Starvation counter must hold STARVE_LIMIT and be at least two bits wide.
  function automatic int unsigned starve_width(input int unsigned limit);
    return (limit < 3) ? 2 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

endpackage

// File: rtl/access_counter.sv
// 32-bit enable-increment counter with asynchronous active-high clear; wraps to 0.
module access_counter
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  output word_t count
);

  word_t count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one RAM port between icache reads and dcache reads/writes, dcache first,
// with dcache bursts locked in and a starvation limit that forces a yield to icache.
module memory_arbiter
  import cpu_types_pkg::*;
  import cache_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      RST,
  // icache read port
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  // dcache port
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  // RAM port
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  // completed-access counters
  output word_t     icount,
  output word_t     dcount
);

  localparam int unsigned StarveW = starve_width(STARVE_LIMIT);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  arb_state_t         state_q, state_d;
  logic [StarveW-1:0] starve_q;
  logic               dreq, ram_acc, starve_hit;
  logic               i_inc, d_inc;

  assign dreq    = dREN | dWEN;
  assign ram_acc = (ramstate == ACCESS);
  // True when the access completing this cycle brings the run to the limit.
  assign starve_hit = (32'(starve_q) + 32'd1) >= STARVE_LIMIT;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dreq) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!dreq) begin
          state_d = iREN ? IGRANT : IDLE;
        end else if (ram_acc && iREN && starve_hit) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        if (!iREN || ram_acc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != DGRANT) begin
        starve_q <= '0;
      end else if (ram_acc && (starve_q != StarveMax)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // ERROR is not ACCESS, so it naturally holds wait, grant and counters like BUSY.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    i_inc    = 1'b0;
    d_inc    = 1'b0;
    unique case (state_q)
      DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = !ram_acc;
        d_inc    = ram_acc & dreq;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = !ram_acc;
        i_inc   = ram_acc & iREN;
      end
      default: ;
    endcase
  end

  access_counter u_icount (
    .clk   (CLK),
    .rst   (RST),
    .en    (i_inc),
    .count (icount)
  );

  access_counter u_dcount (
    .clk   (CLK),
    .rst   (RST),
    .en    (d_inc),
    .count (dcount)
  );

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed scoreboard bench for memory_arbiter against a behavioural model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned Limit = 4;
  localparam int OwnNone = 0;
  localparam int OwnD    = 1;
  localparam int OwnI    = 2;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  word_t     icount, dcount;

  memory_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .icount   (icount),
    .dcount   (dcount)
  );

  always #5 CLK = ~CLK;

  // One entry per cycle in which the model expects a wait line to drop.
  typedef struct {
    logic  is_d;
    word_t addr;
    logic  ren;
    logic  wen;
    word_t store;
    word_t load;
    word_t ic;
    word_t dc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_owner = OwnNone;
  int unsigned m_streak = 0;
  word_t       m_ic = '0;
  word_t       m_dc = '0;
  logic        d_done = 1'b0;
  logic        i_done = 1'b0;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model by that cycle.
  task automatic cyc(input logic ir, input word_t ia, input logic dr, input logic dw,
                     input word_t da, input word_t ds, input ramstate_t rs);
    word_t rl;
    logic  dq, acc;
    exp_t  e;
    @(posedge CLK);
    #1;
    rl = $urandom;
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
    dq = dr | dw;
    acc = (rs == ACCESS);
    d_done = 1'b0;
    i_done = 1'b0;
    e.ic = m_ic;
    e.dc = m_dc;
    e.load = rl;
    case (m_owner)
      OwnD: begin
        if (acc) begin
          e.is_d = 1'b1; e.addr = da; e.ren = dr; e.wen = dw; e.store = ds;
          sb.push_back(e);
          if (dq) begin
            d_done = 1'b1;
            m_dc++;
          end
          if (m_streak < Limit) m_streak++;
        end
        if (!dq) m_owner = ir ? OwnI : OwnNone;
        else if (acc && ir && (m_streak >= Limit)) m_owner = OwnI;
      end
      OwnI: begin
        m_streak = 0;
        if (acc) begin
          e.is_d = 1'b0; e.addr = ia; e.ren = ir; e.wen = 1'b0; e.store = '0;
          sb.push_back(e);
          if (ir) begin
            i_done = 1'b1;
            m_ic++;
          end
        end
        if (!ir || acc) m_owner = OwnNone;
      end
      default: begin
        m_streak = 0;
        if (dq) m_owner = OwnD;
        else if (ir) m_owner = OwnI;
      end
    endcase
  endtask

  task automatic do_reset();
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (2) @(negedge CLK);
    m_owner = OwnNone; m_streak = 0; m_ic = '0; m_dc = '0;
    d_done = 1'b0; i_done = 1'b0;
    sb.delete();
    #2 RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b0 && (dwait === 1'b0 || iwait === 1'b0)) begin
      check1("one_port_only", dwait | iwait, 1'b1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: dwait=%b iwait=%b ramaddr=%h, expected both waiting",
                 dwait, iwait, ramaddr);
      end else begin
        e = sb.pop_front();
        check1("port_is_d", ~dwait, e.is_d);
        check("ramaddr", ramaddr, e.addr);
        check1("ramREN", ramREN, e.ren);
        check1("ramWEN", ramWEN, e.wen);
        check("ramstore", ramstore, e.store);
        check("load_sel", e.is_d ? dload : iload, e.load);
        check("load_unsel", e.is_d ? iload : dload, 32'h0);
        check("icount", icount, e.ic);
        check("dcount", dcount, e.dc);
      end
    end
  end

  initial begin
    logic      d_act, d_re, d_we, i_act;
    int        d_left, k;
    word_t     d_a, d_s, i_a;
    ramstate_t rs;

    // Reset holds everything quiet even with live requests and an ACCESS RAM.
    RST = 1'b1;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h789; daddr = 32'h123; dstore = 32'h456;
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    repeat (2) @(negedge CLK);
    check1("rst_ramREN", ramREN, 1'b0);
    check1("rst_ramWEN", ramWEN, 1'b0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check1("rst_iwait", iwait, 1'b1);
    check1("rst_dwait", dwait, 1'b1);
    check("rst_iload", iload, 32'h0);
    check("rst_dload", dload, 32'h0);
    check("rst_icount", icount, 32'h0);
    check("rst_dcount", dcount, 32'h0);

    // Simultaneous request: one IDLE cycle, then dcache wins.
    do_reset();
    cyc(1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, ACCESS);
    @(negedge CLK);
    check1("sim_c1_dwait", dwait, 1'b1);
    check1("sim_c1_iwait", iwait, 1'b1);
    check1("sim_c1_ramREN", ramREN, 1'b0);
    cyc(1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, ACCESS);
    @(negedge CLK);
    check("sim_c2_ramaddr", ramaddr, 32'h100);
    check1("sim_c2_dwait", dwait, 1'b0);
    check1("sim_c2_iwait", iwait, 1'b1);
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS);
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS);

    // Two-word writeback with iREN held: both words before any icache access.
    do_reset();
    cyc(1'b1, 32'h80, 1'b0, 1'b1, 32'h200, 32'hA0, BUSY);
    for (int w = 0; w < 2; w++) begin
      for (int n = 0; n < 3; n++) begin
        cyc(1'b1, 32'h80, 1'b0, 1'b1, 32'h200 + 32'(w * 4), 32'hA0 + 32'(w * 4),
            (n == 2) ? ACCESS : BUSY);
      end
    end
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, BUSY);
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS);
    @(negedge CLK);
    check("burst_dcount", dcount, 32'h2);

    // Starvation: after Limit dcache accesses icache gets exactly one, then dcache resumes.
    do_reset();
    for (int n = 0; n < 10; n++) begin
      cyc(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, ACCESS);
      @(negedge CLK);
      if (n == 5) begin
        check("starve_ramaddr", ramaddr, 32'h40);
        check1("starve_iwait", iwait, 1'b0);
        check("starve_iload", iload, ramload);
      end
      if (n == 7) check1("starve_resume_dwait", dwait, 1'b0);
    end

    // ERROR behaves as BUSY during an icache grant.
    do_reset();
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, ERROR);
      @(negedge CLK);
      check1("err_iwait", iwait, 1'b1);
    end
    cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE);
    @(negedge CLK);
    check("err_icount", icount, 32'h1);

    // Reset in the middle of a dcache grant drops the RAM enables at once.
    do_reset();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS);
    @(posedge CLK);
    #1;
    check1("pre_rst_ramREN", ramREN, 1'b1);
    RST = 1'b1;
    #1;
    check1("midrst_ramREN", ramREN, 1'b0);
    check1("midrst_ramWEN", ramWEN, 1'b0);
    check1("midrst_dwait", dwait, 1'b1);
    check1("midrst_iwait", iwait, 1'b1);
    check("midrst_icount", icount, 32'h0);
    check("midrst_dcount", dcount, 32'h0);
    do_reset();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS);
    @(negedge CLK);
    check1("restart_ramREN", ramREN, 1'b0);
    check1("restart_dwait", dwait, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS);
    @(negedge CLK);
    check1("restart_dwait2", dwait, 1'b0);

    // dcount wrap from all-ones.
    do_reset();
    @(negedge CLK);
    force dut.u_dcount.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_dcount.count_q;
    m_dc = 32'hFFFF_FFFF;
    check("wrap_preload", dcount, 32'hFFFF_FFFF);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, ACCESS);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, ACCESS);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE);
    @(negedge CLK);
    check("wrap_dcount", dcount, 32'h0);

    // Randomized traffic: requesters hold each request until the model says it completed.
    do_reset();
    d_act = 1'b0; i_act = 1'b0; d_re = 1'b0; d_we = 1'b0; d_left = 0;
    d_a = '0; d_s = '0; i_a = '0;
    for (int n = 0; n < 2000; n++) begin
      if (d_done) begin
        d_left--;
        d_a += 32'd4;
        d_s = $urandom;
        if (d_left == 0) d_act = 1'b0;
      end
      if (i_done) i_act = 1'b0;
      if (!d_act && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 3);
        d_act = 1'b1;
        d_a = $urandom & 32'hFFFF_FFF8;
        d_s = $urandom;
        d_re = (k != 2);
        d_we = (k >= 2);
        d_left = (k == 1 || k == 2) ? 2 : 1;
      end
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1'b1;
        i_a = $urandom & 32'hFFFF_FFFC;
      end
      k = $urandom_range(0, 19);
      rs = (k < 10) ? ACCESS : (k < 14) ? BUSY : (k < 17) ? ERROR : FREE;
      cyc(i_act, i_a, d_act & d_re, d_act & d_we, d_a, d_s, rs);
    end
    repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS);
    @(negedge CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    check("final_icount", icount, m_ic);
    check("final_dcount", dcount, m_dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive dcache RAM accesses granted while iREN is pending.
REQ-002 SHALL have ports CLK, in, 1, the single clock.
REQ-003 SHALL have ports RST, in, 1, reset (asynchronous, active-high).
REQ-004 SHALL have iREN in 1, iaddr in 32, iwait out 1, iload out 32: the icache read port.
REQ-005 SHALL have dREN in 1, dWEN in 1, daddr in 32, dstore in 32, dwait out 1, dload out 32: the dcache port.
REQ-006 SHALL have ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32, ramload in 32, ramstate in ramstate_t (FREE/BUSY/ACCESS/ERROR): the single RAM port.
REQ-007 SHALL have icount out 32 and dcount out 32: completed-access counters for icache and dcache.

Function
REQ-008 SHALL implement FSM states IDLE, DGRANT, IGRANT; the state register is the only grant storage.
REQ-009 IDLE: if dREN|dWEN then next DGRANT; else if iREN then next IGRANT; else stay. dcache wins a simultaneous request.
REQ-010 IDLE SHALL drive no RAM enables, iwait=1, dwait=1 (requests are granted the cycle after they are raised, which gives one cycle of arbitration latency).
REQ-011 DGRANT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore, dload=ramload, dwait = (ramstate!=ACCESS), iwait=1.
REQ-012 IGRANT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0, iload=ramload, iwait = (ramstate!=ACCESS), dwait=1.
REQ-013 Burst lock: DGRANT SHALL persist while dREN|dWEN stays high, so the two-word fill and two-word writeback sequences complete without interleaving.
REQ-014 SHALL count each DGRANT cycle with ramstate==ACCESS in a saturating 2-bit-or-wider starvation counter, cleared in IDLE and IGRANT.
REQ-015 When the starvation counter reaches STARVE_LIMIT on an ACCESS cycle while iREN=1, next state SHALL be IGRANT (forced yield), even if dcache still requests.
REQ-016 DGRANT with dREN=dWEN=0: next IGRANT if iREN, else IDLE.
REQ-017 IGRANT SHALL return to IDLE on the cycle iREN=1 and ramstate==ACCESS, or when iREN=0. A single icache access therefore never blocks dcache for more than one RAM access.
REQ-018 ramstate==ERROR SHALL be treated as BUSY: wait stays high, grant is held, and counters do not advance.
REQ-019 Unselected load outputs (iload/dload) SHALL read 0.
REQ-020 icount SHALL increment on each IGRANT cycle with iREN=1 and ramstate==ACCESS; dcount likewise on DGRANT with (dREN|dWEN). Both SHALL wrap at 2^32-1 to 0.
REQ-021 dREN and dWEN both high SHALL issue both to RAM unchanged; the arbiter SHALL NOT filter them.

Reset
REQ-022 On RST=1, asynchronously: state=IDLE, starvation counter=0, icount=0, dcount=0.
REQ-023 While RST=1: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
REQ-024 Reset asserted mid-burst SHALL abandon the transfer with no RAM enable on the next edge; after release, arbitration restarts from IDLE.

Structure
REQ-025 arb_state_t (IDLE, DGRANT, IGRANT) SHALL reside in cache_pkg; ramstate_t and word_t SHALL come from cpu_types_pkg.
REQ-026 The RAM mux, wait, and load logic SHALL be purely combinational from state. Only state, the starvation counter, and the access counters are flopped.
REQ-027 One sub-module, access_counter (32-bit enable-increment, async active-high clear), SHALL be instantiated twice, for icount and dcount.

Verification
REQ-028 Reset: RST pulse mid-DGRANT with ramstate=ACCESS -> same cycle ramREN=ramWEN=0, dwait=iwait=1, and icount=dcount=0.
REQ-029 Simultaneous request: iREN=1, dREN=1, daddr=0x100, ramstate=ACCESS -> cycle 1 IDLE both wait, cycle 2 ramaddr=0x100 with dwait=0, iwait=1.
REQ-030 Burst lock: dcache writeback 0x200 then 0x204, ramstate BUSY 2 cycles then ACCESS each word, iREN held -> both dcache words complete before any ramaddr=iaddr, and dcount=2.
REQ-031 Starvation: STARVE_LIMIT=4, dREN held continuously, ramstate=ACCESS, iREN=1, iaddr=0x40 -> after 4 dcache accesses, next grant is IGRANT with ramaddr=0x40 and iload=ramload; afterwards DGRANT resumes.
REQ-032 ERROR handling: IGRANT with ramstate=ERROR for 3 cycles then ACCESS -> iwait=1 for 3 cycles, icount increments exactly once.
REQ-033 Wrap: preload dcount to 0xFFFFFFFF via 2^32-1 accesses (or force) then one access -> dcount=0.
